// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/gnt/rvalid bus
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and instruction fetch FSM (optional FETCH_MISALIGN_CHECK_EN trap)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      CLK,
    input  logic                      RST,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall,
    input  logic                      PCSrc,
    input  logic [31:0]               ImmExt,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [6:0]                op,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                      misalign_err
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] next_pc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        seq_pc    = pc_q + 32'd4;
        branch_pc = pc_q + ImmExt;
        next_pc   = PCSrc ? branch_pc : seq_pc;

        case (state_q)
            S_FETCH: begin
                // rvalid is meaningless before the grant, so only gnt moves us on
                if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    pc_d = next_pc;
                    if (PCSrc && (branch_pc[1:0] != 2'b00)) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = next_pc & 32'hFFFF_FFFC;
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Gating with RST keeps the request low while reset is held even though the state is FETCH
    assign imem.imem_req  = (state_q == S_FETCH) && RST;
    assign imem.imem_addr = pc_q;

    assign instr_valid = (state_q == S_ISSUE);
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_err = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem        (bus),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .instr_valid (instr_valid),
        .instr       (instr),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Zero-wait fetch starting in FETCH; returns at the first ISSUE cycle
    task automatic fetch0(input string tag, input logic [31:0] a, input logic [31:0] w);
        chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
        chk({tag, "_addr"}, bus.imem_addr, a);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        chk({tag, "_wait_req"}, {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = w;
        step();
        bus.imem_rvalid = 1'b0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, w);
        chk({tag, "_pc"}, pc, a);
    endtask

    initial begin
        RST             = 1'b0;
        stall           = 1'b0;
        PCSrc           = 1'b0;
        ImmExt          = 32'd0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;

        repeat (3) begin
            step();
            chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        end
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0000_0100);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif

        RST = 1'b1;
        #1;
        fetch0("f1", 32'h0000_0100, 32'h0050_0093);
        chk("f1_op", {25'd0, op}, 32'h13);
        chk("f1_funct3", {29'd0, funct3}, 32'd0);
        chk("f1_funct7", {25'd0, funct7}, 32'd0);
        chk("f1_pc_plus4", pc_plus4, 32'h0000_0104);
        step();
        chk("f1_valid_one_cycle", {31'd0, instr_valid}, 32'd0);

        fetch0("f2", 32'h0000_0104, 32'h40B5_0533);
        chk("f2_op", {25'd0, op}, 32'h33);
        chk("f2_funct7", {25'd0, funct7}, 32'h20);
        PCSrc  = 1'b1;
        ImmExt = 32'h0000_00FC;
        step();

        fetch0("f3", 32'h0000_0200, 32'h0000_0063);
        stall  = 1'b1;
        ImmExt = 32'h0000_1000;
        step();
        chk("f3_stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("f3_stall_pc", pc, 32'h0000_0200);
        stall  = 1'b0;
        ImmExt = 32'hFFFF_FFF8;
        step();
        PCSrc  = 1'b0;

        // slow memory: two idle grant cycles, then gnt with a stray rvalid
        chk("slow_req0", {31'd0, bus.imem_req}, 32'd1);
        chk("slow_addr0", bus.imem_addr, 32'h0000_01F8);
        step();
        chk("slow_addr1", bus.imem_addr, 32'h0000_01F8);
        step();
        chk("slow_req2", {31'd0, bus.imem_req}, 32'd1);
        chk("slow_addr2", bus.imem_addr, 32'h0000_01F8);
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        chk("slow_wait_req", {31'd0, bus.imem_req}, 32'd0);
        chk("slow_wait_valid0", {31'd0, instr_valid}, 32'd0);
        step();
        chk("slow_wait_valid1", {31'd0, instr_valid}, 32'd0);
        step();
        chk("slow_wait_valid2", {31'd0, instr_valid}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0020_8113;
        step();
        bus.imem_rvalid = 1'b0;
        chk("slow_valid", {31'd0, instr_valid}, 32'd1);
        chk("slow_instr", instr, 32'h0020_8113);
        stall = 1'b1;
        step();
        chk("slow_stall1", {31'd0, instr_valid}, 32'd1);
        step();
        chk("slow_stall2", {31'd0, instr_valid}, 32'd1);
        stall  = 1'b0;
        PCSrc  = 1'b1;
        ImmExt = 32'hFFFF_FE04;
        step();
        PCSrc  = 1'b0;
        chk("slow_done_valid", {31'd0, instr_valid}, 32'd0);

        fetch0("f5", 32'hFFFF_FFFC, 32'h0000_0013);
        chk("f5_pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        step();

        fetch0("f6", 32'h0000_0000, 32'h0000_0013);
        PCSrc  = 1'b1;
        ImmExt = 32'h0000_0040;
        step();

        fetch0("f7", 32'h0000_0040, 32'h0000_0063);
        PCSrc  = 1'b1;
        ImmExt = 32'h0000_0006;
        step();
        PCSrc  = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
        chk("trap_err", {31'd0, misalign_err}, 32'd1);
        chk("trap_req", {31'd0, bus.imem_req}, 32'd0);
        chk("trap_valid", {31'd0, instr_valid}, 32'd0);
        chk("trap_pc", pc, 32'h0000_0046);
        step();
        step();
        chk("trap_req_hold", {31'd0, bus.imem_req}, 32'd0);
        chk("trap_err_hold", {31'd0, misalign_err}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("trap_rst_err", {31'd0, misalign_err}, 32'd0);
`else
        chk("align_req", {31'd0, bus.imem_req}, 32'd1);
        chk("align_addr", bus.imem_addr, 32'h0000_0044);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        chk("align_wait_req", {31'd0, bus.imem_req}, 32'd0);
        #2;
        RST = 1'b0;
        #1;
`endif
        chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("midrst_pc", pc, 32'h0000_0100);
        chk("midrst_instr", instr, 32'h0000_0013);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        RST = 1'b1;
        #1;
        chk("rerun_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rerun_addr", bus.imem_addr, 32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
